// File: rtl/fp_pkg.sv
// Shared types and widths for the fp_sched slice.
// The 10-bit word is sign[9], exp[8:5], mant[4:0].
package fp_pkg;

  localparam int FP_W      = 10;
  localparam int FP_EXP_W  = 4;
  localparam int FP_MANT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } fp_sched_state_t;

endpackage

// File: rtl/fp_sched_if.sv
// Requester and response channels of fp_sched.
// master = requester/consumer side, slave = scheduler.
interface fp_sched_if
  import fp_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*FP_W-1:0] req_a;
  logic [N_REQ*FP_W-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [FP_W-1:0]       rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/fp_sched_rr_arb.sv
// Combinational round-robin arbiter.
// Search starts at i_ptr and wraps; first set request wins.
module rr_arb #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx
);

  int   w_j;
  logic w_hit;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_hit = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_hit && i_req[w_j]) begin
        w_hit      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/fp_sched.sv
// Round-robin sharing of one fp unit among N_REQ requesters.
// The unit stays in reset except while an operation runs.
module fp_sched
  import fp_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int FP_LAT = 3
) (
  input  logic            clk,
  input  logic            rst,
  fp_sched_if.slave       bus,
  output logic [FP_W-1:0] fp_a,
  output logic [FP_W-1:0] fp_b,
  output logic            fp_rst,
  input  logic [FP_W-1:0] fp_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(FP_LAT) + 1;

  fp_sched_state_t r_state;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [FP_W-1:0] r_a;
  logic [FP_W-1:0] r_b;
  logic [IW-1:0]   r_id;
  logic [FP_W-1:0] r_data;

  logic [N_REQ-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_take;
  logic [IW-1:0]    w_ptr_nxt;

  rr_arb #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_arb (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_take    = (r_state == ST_IDLE) && (|bus.req_valid);
  assign w_ptr_nxt = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);

  assign bus.req_ready = (r_state == ST_IDLE) ? w_gnt : '0;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_id    = r_id;
  assign bus.rsp_data  = r_data;

  assign fp_a   = r_a;
  assign fp_b   = r_b;
  assign fp_rst = (r_state != ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_a     <= bus.req_a[w_idx*FP_W +: FP_W];
            r_b     <= bus.req_b[w_idx*FP_W +: FP_W];
            r_id    <= w_idx;
            r_ptr   <= w_ptr_nxt;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= CW'(FP_LAT - 1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cnt == '0) begin
            r_data  <= fp_out;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sched.sv
// Scenario bench for fp_sched with an XOR stand-in for the fp unit.
// Responses are matched against a queue of expected id/data pairs.
module tb_fp_sched;
  import fp_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  typedef struct packed {
    logic [1:0] id;
    logic [9:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_sched_if #(.N_REQ(N)) bus ();

  logic [9:0] fp_a, fp_b, fp_out;
  logic       fp_rst;

  fp_sched #(
    .N_REQ  (N),
    .FP_LAT (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .fp_a   (fp_a),
    .fp_b   (fp_b),
    .fp_rst (fp_rst),
    .fp_out (fp_out)
  );

  // Stand-in unit: result only valid LAT cycles after reset falls.
  int fcnt = 0;
  always @(posedge clk) fcnt <= fp_rst ? 0 : fcnt + 1;
  assign fp_out = (!fp_rst && fcnt >= LAT - 1) ? (fp_a ^ fp_b)
                                               : 10'h155;

  int   vec = 0;
  int   err = 0;
  int   cyc = 0;
  exp_t q[$];
  logic [9:0] A [N];
  logic [9:0] B [N];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] xr(input int i);
    return A[i] ^ B[i];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else if (bus.rsp_valid && bus.rsp_ready) begin
      vec++;
      if (q.size() == 0) begin
        err++;
        $display("FAIL rsp_unexpected got id=%0d data=%b exp none",
                 bus.rsp_id, bus.rsp_data);
      end else begin
        e = q.pop_front();
        if ({bus.rsp_id, bus.rsp_data} !== e) begin
          err++;
          $display("FAIL rsp got id=%0d data=%b exp id=%0d data=%b",
                   bus.rsp_id, bus.rsp_data, e.id, e.d);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int k = 0; k < 20 && g == 4'b0; k++) begin
      @(negedge clk);
      g = bus.req_ready;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++;
    if (fp_rst !== 1'b1) begin
      err++; $display("FAIL rst_fp_rst got=%b exp=1", fp_rst);
    end
    vec++;
    if (bus.rsp_valid !== 1'b0) begin
      err++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid);
    end
    vec++;
    if (bus.req_ready !== 4'b0) begin
      err++; $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready);
    end
    vec++;
    if (fp_a !== 10'd0 || fp_b !== 10'd0) begin
      err++; $display("FAIL rst_fp_ops got=%b/%b exp=0", fp_a, fp_b);
    end
    vec++;
    if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 10'd0) begin
      err++;
      $display("FAIL rst_rsp got=%0d/%b exp=0", bus.rsp_id, bus.rsp_data);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [3:0] g;
    tick();
    bus.req_valid = 4'b0001;
    wait_grant(g);
    vec++;
    if (g !== 4'b0001) begin
      err++; $display("FAIL single_grant got=%b exp=0001", g);
    end
    q.push_back({2'd0, 10'b0000110100});
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    vec++;
    if (fp_rst !== 1'b1 || fp_a !== A[0] || fp_b !== B[0]) begin
      err++;
      $display("FAIL single_load got=%b %b %b exp=1 %b %b",
               fp_rst, fp_a, fp_b, A[0], B[0]);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec++;
      if (fp_rst !== 1'b0) begin
        err++; $display("FAIL single_run%0d got=%b exp=0", k, fp_rst);
      end
    end
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b1) begin
      err++; $display("FAIL single_rsp_rise got=%b exp=1", bus.rsp_valid);
    end
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b0) begin
      err++; $display("FAIL single_rsp_fall got=%b exp=0", bus.rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    logic [3:0] e;
    int         last;
    last = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      e = 4'(1 << (n % 4));
      vec++;
      if (g !== e) begin
        err++; $display("FAIL rr_grant%0d got=%b exp=%b", n, g, e);
      end
      if (n > 0) begin
        vec++;
        if (cyc - last !== 6) begin
          err++; $display("FAIL rr_gap%0d got=%0d exp=6", n, cyc - last);
        end
      end
      last = cyc;
      q.push_back({2'(n % 4), xr(n % 4)});
      tick();
    end
    bus.req_valid = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [3:0] g;
    tick();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    wait_grant(g);
    vec++;
    if (g !== 4'b0100) begin
      err++; $display("FAIL bp_grant got=%b exp=0100", g);
    end
    q.push_back({2'd2, xr(2)});
    tick();
    bus.req_valid = 4'b0001;
    for (int k = 0; k < 20 && !bus.rsp_valid; k++) @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b1) begin
      err++; $display("FAIL bp_timeout got=%b exp=1", bus.rsp_valid);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 ||
          bus.rsp_data !== xr(2) || bus.req_ready !== 4'b0) begin
        err++;
        $display("FAIL bp_hold%0d got=%b %0d %b %b exp=1 2 %b 0000",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_data,
                 bus.req_ready, xr(2));
      end
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 4'b0) begin
      err++; $display("FAIL bp_release got=%b exp=0000", bus.req_ready);
    end
    @(negedge clk);
    vec++;
    if (bus.req_ready !== 4'b0001 || bus.rsp_valid !== 1'b0) begin
      err++;
      $display("FAIL bp_idle got=%b %b exp=0001 0",
               bus.req_ready, bus.rsp_valid);
    end
    q.push_back({2'd0, xr(0)});
    tick();
    bus.req_valid = 4'b0000;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_midop_reset;
    logic [3:0] g;
    tick();
    bus.req_valid = 4'b0100;
    wait_grant(g);
    vec++;
    if (g !== 4'b0100) begin
      err++; $display("FAIL mid_grant got=%b exp=0100", g);
    end
    q.push_back({2'd2, xr(2)});
    tick();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    vec++;
    if (fp_rst !== 1'b0) begin
      err++; $display("FAIL mid_run got=%b exp=0", fp_rst);
    end
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b0 || fp_rst !== 1'b1 ||
        bus.req_ready !== 4'b0010) begin
      err++;
      $display("FAIL mid_after got=%b %b %b exp=0 1 0010",
               bus.rsp_valid, fp_rst, bus.req_ready);
    end
    q.push_back({2'd1, xr(1)});
    tick();
    bus.req_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vec++;
      if (bus.rsp_valid !== 1'b0) begin
        err++; $display("FAIL mid_norsp%0d got=1 exp=0", k);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ptr_wrap;
    logic [3:0] g;
    tick();
    bus.req_valid = 4'b1000;
    wait_grant(g);
    vec++;
    if (g !== 4'b1000) begin
      err++; $display("FAIL wrap_g3 got=%b exp=1000", g);
    end
    q.push_back({2'd3, xr(3)});
    tick();
    bus.req_valid = 4'b1001;
    wait_grant(g);
    vec++;
    if (g !== 4'b0001) begin
      err++; $display("FAIL wrap_g0 got=%b exp=0001", g);
    end
    q.push_back({2'd0, xr(0)});
    tick();
    bus.req_valid = 4'b1000;
    wait_grant(g);
    vec++;
    if (g !== 4'b1000) begin
      err++; $display("FAIL wrap_g3b got=%b exp=1000", g);
    end
    q.push_back({2'd3, xr(3)});
    tick();
    bus.req_valid = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    A[0] = 10'b0100101100; B[0] = 10'b0100011000;
    A[1] = 10'h3A1;        B[1] = 10'h155;
    A[2] = 10'h0F0;        B[2] = 10'h2AB;
    A[3] = 10'h2C7;        B[3] = 10'h01E;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*10 +: 10] = A[i];
      bus.req_b[i*10 +: 10] = B[i];
    end
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_midop_reset();
    test_ptr_wrap();
    vec++;
    if (q.size() !== 0) begin
      err++; $display("FAIL pending got=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/fp_sched.md
# fp_sched

Round-robin scheduler that shares one 10-bit floating-point unit (`fp`) among `N_REQ` requesters. It accepts one operand pair at a time over a valid/ready handshake and sequences the unit: it loads the operands, pulses the unit's reset, and waits a fixed latency. It then captures the result and returns it with the requester id over a valid/ready response channel. It sits between the requester-side datapath and the single `fp` instance.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `FP_LAT`, default 3: cycles from `fp_rst` falling to a valid `fp_out`, at least 1.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N_REQ: per-requester request valid.
- `req_ready`, out, N_REQ: per-requester accept, one-hot or zero.
- `req_a`, in, N_REQ*10: packed operand A; requester i uses bits [10i+9:10i].
- `req_b`, in, N_REQ*10: packed operand B, same packing as `req_a`.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: consumer accepts the result.
- `rsp_id`, out, $clog2(N_REQ): index of the requester that owns the result.
- `rsp_data`, out, 10: result word (sign[9], exp[8:5], mant[4:0]).
- `fp_a`, out, 10: operand A to the unit.
- `fp_b`, out, 10: operand B to the unit.
- `fp_rst`, out, 1: reset/start to the unit.
- `fp_out`, in, 10: unit result.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE:
  - Round-robin search of `req_valid` starting at pointer `ptr`, wrapping.
  - `req_ready[g]` = 1 combinationally for the winner g only.
  - On handshake, latch `req_a[g]`, `req_b[g]` and g; set `ptr` = (g+1) mod N_REQ; go to LOAD.
  - No valid request: stay in IDLE, `req_ready` = 0.
- LOAD: one cycle with `fp_rst`=1 and the latched operands on `fp_a`/`fp_b`. Load counter with FP_LAT-1. Go to RUN.
- RUN:
  - `fp_rst`=0; operands held stable.
  - When the counter is 0, capture `fp_out` into `rsp_data` and go to DONE. Otherwise decrement.
- DONE:
  - `rsp_valid`=1; `rsp_data`/`rsp_id` held stable until `rsp_ready`=1.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle as `rsp_ready`.
- `fp_rst` is 1 in every state except RUN, so the unit is parked in reset while unused.
- `req_ready` is 0 in all states except IDLE.
- Requesters must not make `req_valid` depend on `req_ready`.
- Once asserted, `req_valid` and its operands must hold until accepted.
- Result arithmetic is fully owned by `fp`; this block neither inspects nor modifies the 10-bit word.

## Timing
- Handshake at cycle T (IDLE), LOAD at T+1, RUN over T+2..T+1+FP_LAT.
- `rsp_valid` rises at T+2+FP_LAT. Minimum occupancy per operation is FP_LAT+3 cycles.
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0.
  - `fp_a`=0, `fp_b`=0, `fp_rst`=1.
  - `ptr`=0, counter=0.
- Reset in any state returns to IDLE next cycle. The in-flight operation is dropped with no response, and `ptr` returns to 0.
- Single requester held valid: back-to-back service, one op per FP_LAT+3 cycles when `rsp_ready` is tied high.
- All requesters valid: grants run 0,1,2,3,0,…; no requester waits more than N_REQ operations.
- `rsp_ready` held low: block stalls in DONE indefinitely and `req_ready` stays 0.

## Structure
- Shared package `fp_pkg`:
  - `FP_W`=10, `FP_EXP_W`=4, `FP_MANT_W`=5.
  - FSM state enum `fp_sched_state_t`.
- One sub-module `rr_arb`:
  - Inputs: N_REQ request vector and pointer.
  - Outputs: one-hot grant and binary index.
  - Purely combinational.
- `ptr`, FSM, counter and result registers live in `fp_sched`.

## Test plan
Bench stub for `fp`: `fp_out` = a XOR b, valid FP_LAT cycles after `fp_rst` falls. FP_LAT=3, N_REQ=4.
1. Reset check: `rst` high 3 cycles -> `fp_rst`=1, `rsp_valid`=0, `req_ready`=0, `fp_a`=0.
2. Single op: req 0, a=0100101100, b=0100011000 at cycle T -> `req_ready[0]`=1 at T; `fp_rst`=1 at T+1, 0 over T+2..T+4; `rsp_valid` at T+5 with id=0 and data=0000110100.
3. Round-robin: all four requests valid continuously, `rsp_ready`=1 -> grants 0,1,2,3,0, spaced 6 cycles apart; ids match the grant order.
4. Back-pressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` -> `rsp_data`/`rsp_id` stable, no `req_ready`; release -> IDLE next cycle.
5. Mid-op reset: assert `rst` during RUN -> next cycle IDLE, `rsp_valid` never rises for that op, and the next grant goes to the lowest valid index.
6. Pointer wrap: req 3 only, then reqs 0 and 3 both valid -> req 0 granted first.
